window_mean: RTL and testbench

// - Parametrised windowed-mean engine for the RMS_finder datapath: accumulates a runtime-selectable

---
 rtl/window_mean_pkg.sv | 25 ++
 rtl/window_mean_if.sv | 27 ++
 rtl/window_mean_seq_divider.sv | 94 +++++++++
 rtl/window_mean.sv | 138 +++++++++++++
 tb/tb_window_mean.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/window_mean_pkg.sv
// Shared types and helpers for the window_mean engine.
package window_mean_pkg;

  // Sequential divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Ceiling log2, used to size the divider iteration counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/window_mean_if.sv
// Sample-in / mean-out bus of the window_mean engine.
// master: sample source and result sink; slave: the engine itself.
interface window_mean_if #(
  parameter int DATA_W = 12,
  parameter int LEN_W  = 16
);
  localparam int ACC_W = DATA_W + LEN_W;

  logic [LEN_W-1:0]  win_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              mean_valid;
  logic [DATA_W-1:0] mean;
  logic [ACC_W-1:0]  mean_sum;
  logic              busy;

  modport master (
    output win_len, in_valid, in_data,
    input  in_ready, mean_valid, mean, mean_sum, busy
  );

  modport slave (
    input  win_len, in_valid, in_data,
    output in_ready, mean_valid, mean, mean_sum, busy
  );
endinterface

// File: rtl/window_mean_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, DIVIDEND_W cycles
// in RUN, then a single DONE cycle in which quotient_o is final.
module seq_divider
  import window_mean_pkg::*;
#(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o
);
  localparam int ITER_W = (clog2(DIVIDEND_W) < 1) ? 1 : clog2(DIVIDEND_W);

  div_state_t            state_q, state_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W:0]    rem_shift_s;
  logic [DIVISOR_W:0]    diff_s;

  assign rem_shift_s = {rem_q, quo_q[DIVIDEND_W-1]};
  assign diff_s      = rem_shift_s - {1'b0, dvs_q};
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign quotient_o  = quo_q;

  // Next state and one restoring step; the dividend shifts out of quo_q as quotient bits shift in.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = RUN;
            iter_d  = '0;
            rem_d   = '0;
            quo_d   = dividend_i;
            dvs_d   = divisor_i;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (!diff_s[DIVISOR_W]) begin
            rem_d = diff_s[DIVISOR_W-1:0];
            quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
          end else begin
            rem_d = rem_shift_s[DIVISOR_W-1:0];
            quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
          end
          if (iter_q == ITER_W'(DIVIDEND_W - 1)) begin
            state_d = DONE;
          end else begin
            iter_d = iter_q + ITER_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
    end
  end

endmodule

// File: rtl/window_mean.sv
// Windowed-mean engine: sums win_len samples, divides by the count, emits
// one mean (and the raw sum) per window.
// Build option WINDOW_MEAN_ROUND_EN: round-half-up instead of truncation.
module window_mean
  import window_mean_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LEN_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  input logic           clear,
  window_mean_if.slave  bus
);
  localparam int ACC_W = DATA_W + LEN_W;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ACC_W-1:0]  sum_pend_q, sum_pend_d;
  logic              mean_valid_q, mean_valid_d;
  logic [DATA_W-1:0] mean_q, mean_d;
  logic [ACC_W-1:0]  mean_sum_q, mean_sum_d;

  logic [LEN_W-1:0]  win_len_eff_s;
  logic [LEN_W-1:0]  len_cur_s;
  logic              completes_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              start_s;
  logic [ACC_W-1:0]  sum_next_s;
  logic [ACC_W-1:0]  dividend_s;
  logic              div_busy_s;
  logic              div_done_s;
  logic [ACC_W-1:0]  quotient_s;

  // A zero window length behaves as a window of one; the latched length applies once a window is open.
  assign win_len_eff_s = (bus.win_len == '0) ? LEN_W'(1) : bus.win_len;
  assign len_cur_s     = (cnt_q == '0) ? win_len_eff_s : len_q;
  assign completes_s   = (({1'b0, cnt_q} + (LEN_W + 1)'(1)) == {1'b0, len_cur_s});
  // Stall only the sample that would need the divider while it is still occupied.
  assign in_ready_s    = !(div_busy_s && completes_s);
  assign accept_s      = bus.in_valid && in_ready_s && !clear;
  assign start_s       = accept_s && completes_s;
  assign sum_next_s    = acc_q + ACC_W'(bus.in_data);

`ifdef WINDOW_MEAN_ROUND_EN
  logic [ACC_W:0] dividend_wide_s;
  assign dividend_wide_s = {1'b0, sum_next_s} + (ACC_W + 1)'(len_cur_s >> 1);
  assign dividend_s      = dividend_wide_s[ACC_W] ? {ACC_W{1'b1}} : dividend_wide_s[ACC_W-1:0];
`else
  assign dividend_s      = sum_next_s;
`endif

  seq_divider #(
    .DIVIDEND_W (ACC_W),
    .DIVISOR_W  (LEN_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort_i    (clear),
    .start_i    (start_s),
    .dividend_i (dividend_s),
    .divisor_i  (len_cur_s),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quotient_o (quotient_s)
  );

  assign bus.in_ready   = in_ready_s;
  assign bus.busy       = div_busy_s;
  assign bus.mean_valid = mean_valid_q;
  assign bus.mean       = mean_q;
  assign bus.mean_sum   = mean_sum_q;

  // Accumulator, window counter, hand-off and result capture.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    sum_pend_d   = sum_pend_q;
    mean_valid_d = 1'b0;
    mean_d       = mean_q;
    mean_sum_d   = mean_sum_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      if (div_done_s) begin
        mean_valid_d = 1'b1;
        mean_sum_d   = sum_pend_q;
        mean_d       = (quotient_s[ACC_W-1:DATA_W] != '0) ? {DATA_W{1'b1}}
                                                         : quotient_s[DATA_W-1:0];
      end else begin
        mean_valid_d = 1'b0;
      end
      if (accept_s) begin
        if (cnt_q == '0) begin
          len_d = win_len_eff_s;
        end else begin
          len_d = len_q;
        end
        if (completes_s) begin
          acc_d      = '0;
          cnt_d      = '0;
          sum_pend_d = sum_next_s;
        end else begin
          acc_d = sum_next_s;
          cnt_d = cnt_q + LEN_W'(1);
        end
      end else begin
        acc_d = acc_q;
      end
    end
  end

  // Engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      sum_pend_q   <= '0;
      mean_valid_q <= 1'b0;
      mean_q       <= '0;
      mean_sum_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      sum_pend_q   <= sum_pend_d;
      mean_valid_q <= mean_valid_d;
      mean_q       <= mean_d;
      mean_sum_q   <= mean_sum_d;
    end
  end

endmodule

// File: tb/tb_window_mean.sv
// Directed bench for window_mean with DATA_W=12, LEN_W=4 (ACC_W=16).
module tb_window_mean;
  localparam int DATA_W = 12;
  localparam int LEN_W  = 4;
`ifdef WINDOW_MEAN_ROUND_EN
  localparam int EXP_MEAN_1TO8 = 5;
`else
  localparam int EXP_MEAN_1TO8 = 4;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  window_mean_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  window_mean #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int stall_cnt = 0;
  int last_acc_edge = 0;
  logic [31:0] res_mean[$];
  logic [31:0] res_sum[$];
  int          res_cyc[$];

  // Edge counter: after the k-th rising edge cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor at the falling edge: accepts, stalls and result pulses.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready && !clear) begin
      acc_cnt++;
      last_acc_edge = cyc + 1;
    end
    if (rst_n && bus.in_valid && !bus.in_ready) stall_cnt++;
    if (bus.mean_valid) begin
      res_mean.push_back(32'(bus.mean));
      res_sum.push_back(32'(bus.mean_sum));
      res_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      failures++;
      $display("FAIL send_timeout observed=%0d expected=<100", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_results(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (res_mean.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(tag, 32'(res_mean.size()), 32'(n));
  endtask

  initial begin
    int base;
    int a0;
    int s0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.win_len  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mean_valid", 32'(bus.mean_valid), 32'd0);
    chk("rst_mean", 32'(bus.mean), 32'd0);
    chk("rst_mean_sum", 32'(bus.mean_sum), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // win_len=8, samples 1..8
    bus.win_len = 4'd8;
    base = res_mean.size();
    for (int i = 1; i <= 8; i++) send(DATA_W'(i));
    bus.in_valid = 1'b0;
    chk("t1_busy_after_handoff", 32'(bus.busy), 32'd1);
    chk("t1_ready_while_busy", 32'(bus.in_ready), 32'd1);
    wait_results("t1_count", base + 1, 60);
    if (res_mean.size() > base) begin
      chk("t1_mean", res_mean[base], 32'(EXP_MEAN_1TO8));
      chk("t1_sum", res_sum[base], 32'd36);
      chk("t1_latency", 32'(res_cyc[base] - last_acc_edge), 32'd17);
    end
    chk("t1_busy_idle", 32'(bus.busy), 32'd0);

    // win_len=2, valid held high, back-pressure
    bus.win_len = 4'd2;
    base = res_mean.size();
    a0 = acc_cnt;
    s0 = stall_cnt;
    send(12'd10); send(12'd20); send(12'd30);
    send(12'd40); send(12'd50); send(12'd60);
    bus.in_valid = 1'b0;
    wait_results("t2_count", base + 3, 200);
    if (res_mean.size() >= base + 3) begin
      chk("t2_mean0", res_mean[base], 32'd15);
      chk("t2_mean1", res_mean[base+1], 32'd35);
      chk("t2_mean2", res_mean[base+2], 32'd55);
      chk("t2_sum2", res_sum[base+2], 32'd110);
    end
    chk("t2_accepts", 32'(acc_cnt - a0), 32'd6);
    chk("t2_stalled", 32'(stall_cnt > s0), 32'd1);

    // win_len=0 behaves as 1
    bus.win_len = 4'd0;
    base = res_mean.size();
    send(12'd7); send(12'd4095);
    bus.in_valid = 1'b0;
    wait_results("t3_count", base + 2, 100);
    if (res_mean.size() >= base + 2) begin
      chk("t3_mean0", res_mean[base], 32'd7);
      chk("t3_mean1", res_mean[base+1], 32'd4095);
      chk("t3_sum1", res_sum[base+1], 32'd4095);
    end

    // win_len=15 full scale, no wrap
    bus.win_len = 4'd15;
    base = res_mean.size();
    for (int i = 0; i < 15; i++) send(12'd4095);
    bus.in_valid = 1'b0;
    wait_results("t4_count", base + 1, 60);
    if (res_mean.size() > base) begin
      chk("t4_sum", res_sum[base], 32'd61425);
      chk("t4_mean", res_mean[base], 32'd4095);
    end

    // partial window aborted by clear
    bus.win_len = 4'd4;
    base = res_mean.size();
    send(12'd999); send(12'd999); send(12'd999);
    bus.in_valid = 1'b1;
    bus.in_data  = 12'd999;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_mean_held", 32'(bus.mean), 32'd4095);
    chk("t5_sum_held", 32'(bus.mean_sum), 32'd61425);
    for (int i = 0; i < 4; i++) send(12'd100);
    bus.in_valid = 1'b0;
    wait_results("t5_count", base + 1, 60);
    repeat (30) @(posedge clk);
    #1;
    chk("t5_single_result", 32'(res_mean.size()), 32'(base + 1));
    if (res_mean.size() > base) begin
      chk("t5_mean", res_mean[base], 32'd100);
      chk("t5_sum", res_sum[base], 32'd400);
    end

    // reset in the middle of a division
    bus.win_len = 4'd4;
    for (int i = 0; i < 4; i++) send(12'd50);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_busy_pre", 32'(bus.busy), 32'd1);
    base = res_mean.size();
    rst_n = 1'b0;
    #1;
    chk("t6_mean", 32'(bus.mean), 32'd0);
    chk("t6_sum", 32'(bus.mean_sum), 32'd0);
    chk("t6_valid", 32'(bus.mean_valid), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("t6_no_pulse", 32'(res_mean.size()), 32'(base));
    for (int i = 0; i < 4; i++) send(12'd8);
    bus.in_valid = 1'b0;
    wait_results("t6_count", base + 1, 60);
    if (res_mean.size() > base) begin
      chk("t6_mean_after", res_mean[base], 32'd8);
      chk("t6_sum_after", res_sum[base], 32'd32);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
